nrzi_tx: RTL
============

// Module: nrzi_tx
// PURPOSE
//  USB transmit line encoder, directly downstream of bit_stuff. Takes the stuffed serial
//  stream (bit_stuff outb) and NRZI-encodes it onto the differential pair: 0 = toggle, 1 = hold.
//  Appends EOP (SE0 x EOP_SE0_CYCLES, then one J), drives idle J and generates line output-enable.
//  One bit per clk; clk is the bit clock.
// PARAMETERS
//  EOP_SE0_CYCLES  2  number of SE0 bit times in EOP (legal 1..15)
//  IDLE_J_DP       1  J polarity: 1 = full speed (J: dp=1,dm=0); 0 = low speed (J: dp=0,dm=1)
// PORTS
//  clk       in   1   bit clock, all state on posedge
//  rst       in   1   asynchronous, active-high reset
//  inb       in   1   stuffed bit from bit_stuff outb; valid when tx_en=1
//  tx_en     in   1   high on every cycle that a packet bit is presented; low ends the packet
//  dp        out  1   D+ line value (registered)
//  dm        out  1   D- line value (registered)
//  line_oe   out  1   transceiver drive enable (registered)
//  busy      out  1   state != IDLE
//  eop_done  out  1   one-cycle pulse: EOP complete, line released
//  tx_err    out  1   one-cycle pulse: tx_en asserted while in SE0 or EOP_J
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, lvl=J, dp/dm=J, line_oe=0, busy=0, eop_done=0, tx_err=0,
//   SE0 counter=0. Reset mid-packet abandons the packet with no EOP. The next packet starts from J.
//  lvl: internal 1-bit current line symbol (J/K). J->dp/dm per IDLE_J_DP; K = inverse of J.
//  Latency: 1 clk from inb/tx_en sample to dp/dm/line_oe.
//  FSM:
//   IDLE : dp/dm=J, line_oe=0. tx_en=1 -> DATA; encode inb (see DATA); line_oe<=1.
//          The first packet bit is the first SOP 0, so it produces K.
//   DATA : tx_en=1 -> lvl_n = inb ? lvl : ~lvl; lvl<=lvl_n; dp/dm<=lvl_n; stay.
//          tx_en=0 -> SE0; dp<=0, dm<=0; cnt<=1.
//   SE0  : dp=dm=0. cnt==EOP_SE0_CYCLES -> EOP_J: dp/dm<=J, cnt<=0. Otherwise cnt<=cnt+1.
//   EOP_J: single J cycle with line_oe=1 -> IDLE; line_oe<=0; lvl<=J; eop_done<=1 (1 cycle).
//  The same edge that enters IDLE produces the eop_done pulse, so the pulse is high for the
//   first IDLE cycle.
//  tx_en=1 in SE0/EOP_J: ignored (EOP completes unchanged); tx_err pulses the following cycle.
//  tx_en=1 in the IDLE cycle in which eop_done is high: legal; the new packet starts.
//  A one-bit packet (tx_en high for 1 cycle) is legal: K, then EOP.
//  Packet length is unbounded; no counter wraps in DATA.
//  No stuffing is done here. The stuffed 0 from bit_stuff is encoded like any other 0.
// CONFIGURATION
//  NRZI_BITCNT_EN defined: adds output tx_bitcnt [15:0], the number of bits encoded in the
//   current/last packet. Cleared to 1 on the IDLE->DATA edge. +1 per DATA cycle with tx_en=1.
//   Saturates at 16'hFFFF. Holds through EOP/IDLE until the next packet. Reset value 0.
//  Not defined: port and counter absent. All other behaviour identical.
// TESTING
//  1 rst=1 asynchronously mid-clock -> dp=1, dm=0, line_oe=0, busy=0 at once (IDLE_J_DP=1).
//  2 SOP inb=0000_0001, tx_en 8 cycles -> dp=0,1,0,1,0,1,0,0 on cycles 1..8,
//    dm=~dp, line_oe=1, busy=1.
//  3 after test 2, tx_en=0 -> dp=dm=0 for 2 cycles, then dp=1/dm=0 with line_oe=1 for 1 cycle,
//    then line_oe=0 and eop_done=1 for exactly 1 cycle.
//  4 data 1111110 (six 1s plus stuffed 0) from a K start -> dp holds 0 for 6 cycles,
//    then toggles to 1.
//  5 tx_en=1 during the 2nd SE0 cycle -> tx_err=1 for 1 cycle; EOP timing is identical to test 3.
//  6 rst pulse mid-DATA, then a new SOP -> no EOP emitted; first new bit gives K (dp=0).
//    Repeat tests 2-3 with IDLE_J_DP=0: all dp/dm are swapped.
//    With NRZI_BITCNT_EN: tx_bitcnt=8 after test 2.

Source files
------------

// File: rtl/nrzi_tx.sv
// rtl/nrzi_tx.sv - USB NRZI line encoder with EOP generation, idle J and output enable.
// Optional NRZI_BITCNT_EN adds tx_bitcnt, the bit count of the current/last packet.
module nrzi_tx #(
    parameter int EOP_SE0_CYCLES = 2,
    parameter bit IDLE_J_DP      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inb,
    input  logic        tx_en,
    output logic        dp,
    output logic        dm,
    output logic        line_oe,
    output logic        busy,
    output logic        eop_done,
    output logic        tx_err
`ifdef NRZI_BITCNT_EN
    ,
    output logic [15:0] tx_bitcnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        SE0   = 2'd2,
        EOP_J = 2'd3
    } state_t;

    localparam logic       J_DP     = IDLE_J_DP;
    localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_CYCLES);

    state_t     state, state_n;
    logic       lvl, lvl_n;       // 1 = J, 0 = K
    logic [3:0] cnt, cnt_n;
    logic       dp_n, dm_n, oe_n, eop_n, err_n;
    logic       data_lvl;

`ifdef NRZI_BITCNT_EN
    logic [15:0] bitcnt, bitcnt_n;
    assign tx_bitcnt = bitcnt;
`endif

    function automatic logic sym_dp(input logic sym);
        return sym ? J_DP : ~J_DP;
    endfunction

    assign busy     = (state != IDLE);
    assign data_lvl = inb ? lvl : ~lvl;

    always_comb begin
        state_n = state;
        lvl_n   = lvl;
        cnt_n   = cnt;
        dp_n    = dp;
        dm_n    = dm;
        oe_n    = line_oe;
        eop_n   = 1'b0;
        err_n   = 1'b0;
`ifdef NRZI_BITCNT_EN
        bitcnt_n = bitcnt;
`endif
        case (state)
            IDLE: begin
                dp_n = J_DP;
                dm_n = ~J_DP;
                oe_n = 1'b0;
                if (tx_en) begin
                    state_n = DATA;
                    lvl_n   = data_lvl;
                    dp_n    = sym_dp(data_lvl);
                    dm_n    = ~sym_dp(data_lvl);
                    oe_n    = 1'b1;
`ifdef NRZI_BITCNT_EN
                    bitcnt_n = 16'd1;
`endif
                end
            end
            DATA: begin
                if (tx_en) begin
                    lvl_n = data_lvl;
                    dp_n  = sym_dp(data_lvl);
                    dm_n  = ~sym_dp(data_lvl);
`ifdef NRZI_BITCNT_EN
                    if (bitcnt != 16'hFFFF) bitcnt_n = bitcnt + 16'd1;
`endif
                end else begin
                    state_n = SE0;
                    dp_n    = 1'b0;
                    dm_n    = 1'b0;
                    cnt_n   = 4'd1;
                end
            end
            SE0: begin
                err_n = tx_en;
                if (cnt == SE0_LAST) begin
                    state_n = EOP_J;
                    dp_n    = J_DP;
                    dm_n    = ~J_DP;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            EOP_J: begin
                // tx_en here is an error, not a new packet; the line returns to idle regardless
                err_n   = tx_en;
                state_n = IDLE;
                oe_n    = 1'b0;
                lvl_n   = 1'b1;
                eop_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lvl      <= 1'b1;
            cnt      <= 4'd0;
            dp       <= J_DP;
            dm       <= ~J_DP;
            line_oe  <= 1'b0;
            eop_done <= 1'b0;
            tx_err   <= 1'b0;
`ifdef NRZI_BITCNT_EN
            bitcnt   <= 16'd0;
`endif
        end else begin
            state    <= state_n;
            lvl      <= lvl_n;
            cnt      <= cnt_n;
            dp       <= dp_n;
            dm       <= dm_n;
            line_oe  <= oe_n;
            eop_done <= eop_n;
            tx_err   <= err_n;
`ifdef NRZI_BITCNT_EN
            bitcnt   <= bitcnt_n;
`endif
        end
    end

endmodule
